// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared widths, state encoding and address helper for the MEM/WB slice
package mem_wb_stage_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT
  } state_e;

  // Data memory is word-addressed; the byte offset of the ALU result is dropped.
  function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory req/ack bus between the MEM stage and memory
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB flop bank with bubble insertion and selective load-data update
module mem_wb_register
  import mem_wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  bubble_i,
  input  logic                  mo_we_i,
  input  logic                  wreg_i,
  input  logic                  m2reg_i,
  input  logic [DATA_W-1:0]     mo_i,
  input  logic [DATA_W-1:0]     alu_i,
  input  logic [REG_ADDR_W-1:0] rn_i,
  output logic                  wreg_o,
  output logic                  m2reg_o,
  output logic [DATA_W-1:0]     mo_o,
  output logic [DATA_W-1:0]     alu_o,
  output logic [REG_ADDR_W-1:0] rn_o
);
  logic                  wreg_q;
  logic                  m2reg_q;
  logic [DATA_W-1:0]     mo_q;
  logic [DATA_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] rn_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      mo_q    <= '0;
      alu_q   <= '0;
      rn_q    <= '0;
    end else if (bubble_i) begin
      // Only the write enables are killed; the data fields hold their last values.
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
    end else begin
      wreg_q  <= wreg_i;
      m2reg_q <= m2reg_i;
      alu_q   <= alu_i;
      rn_q    <= rn_i;
      if (mo_we_i) mo_q <= mo_i;
    end
  end

  assign wreg_o  = wreg_q;
  assign m2reg_o = m2reg_q;
  assign mo_o    = mo_q;
  assign alu_o   = alu_q;
  assign rn_o    = rn_q;
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: data-memory req/ack FSM with timeout, upstream stall, MEM/WB register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int                MAX_WAIT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  mem_wreg,
  input  logic                  mem_m2reg,
  input  logic                  mem_wmem,
  input  logic [DATA_W-1:0]     mem_alu,
  input  logic [DATA_W-1:0]     mem_b,
  input  logic [REG_ADDR_W-1:0] mem_rn,
  mem_wb_stage_if.master        dm,
  output logic                  mem_stall,
  output logic                  wb_wreg,
  output logic                  wb_m2reg,
  output logic [DATA_W-1:0]     wb_mo,
  output logic [DATA_W-1:0]     wb_alu,
  output logic [REG_ADDR_W-1:0] wb_rn,
  output logic                  bus_err
);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q;
  logic        acc;
  logic        req_raw;
  logic        stall_raw;
  logic        done_ok;
  logic        done_to;

  assign acc = mem_m2reg | mem_wmem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          req_raw = 1'b1;
          if (dm.dm_ack) begin
            done_ok = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = ST_WAIT;
            cnt_d     = 8'd1;
          end
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (dm.dm_ack) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(MAX_WAIT)) begin
          done_to = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (done_to) bus_err_q <= 1'b1;
    end
  end

  // Reset must drop the request immediately, even though inputs may still show an access.
  assign dm.dm_req   = req_raw & clrn;
  assign dm.dm_we    = mem_wmem & dm.dm_req;
  assign dm.dm_addr  = word_addr(mem_alu);
  assign dm.dm_wdata = mem_b;
  assign mem_stall   = stall_raw & clrn;
  assign bus_err     = bus_err_q;

  mem_wb_register u_wb_reg (
    .clk      (clk),
    .clrn     (clrn),
    .bubble_i (mem_stall),
    .mo_we_i  (mem_m2reg & (done_ok | done_to)),
    .wreg_i   (mem_wreg),
    .m2reg_i  (mem_m2reg),
    .mo_i     (done_to ? ERR_DATA : dm.dm_rdata),
    .alu_i    (mem_alu),
    .rn_i     (mem_rn),
    .wreg_o   (wb_wreg),
    .m2reg_o  (wb_m2reg),
    .mo_o     (wb_mo),
    .alu_o    (wb_alu),
    .rn_o     (wb_rn)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage: reset, plain op, loads, waited store, timeout
module tb_mem_wb_stage;
  localparam logic [31:0] ERR_D = 32'hBAD0_0BAD;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } wb_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mem_wreg, mem_m2reg, mem_wmem;
  logic [31:0] mem_alu, mem_b;
  logic [4:0]  mem_rn;
  logic        mem_stall;
  logic        wb_wreg, wb_m2reg;
  logic [31:0] wb_mo, wb_alu;
  logic [4:0]  wb_rn;
  logic        bus_err;

  int  checks = 0;
  int  errors = 0;
  wb_t sb[$];
  wb_t e;
  wb_t act;
  logic [31:0] model_mo;
  logic [31:0] last_alu;

  mem_wb_stage_if dmb ();

  mem_wb_stage #(.MAX_WAIT(4), .ERR_DATA(ERR_D)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_wmem  (mem_wmem),
    .mem_alu   (mem_alu),
    .mem_b     (mem_b),
    .mem_rn    (mem_rn),
    .dm        (dmb),
    .mem_stall (mem_stall),
    .wb_wreg   (wb_wreg),
    .wb_m2reg  (wb_m2reg),
    .wb_mo     (wb_mo),
    .wb_alu    (wb_alu),
    .wb_rn     (wb_rn),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  assign act = {wb_wreg, wb_m2reg, wb_mo, wb_alu, wb_rn};

  task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                       input logic ack, input logic [31:0] rdata);
    mem_wreg = wreg; mem_m2reg = m2reg; mem_wmem = wmem;
    mem_alu = alu; mem_b = b; mem_rn = rn;
    dmb.dm_ack = ack; dmb.dm_rdata = rdata;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd1, 1'b0, 32'h0);
    #12;
    checks++;
    if (dmb.dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL reset_req_stall: req=%b stall=%b expected 0 0", dmb.dm_req, mem_stall);
    end
    checks++;
    if (act !== '0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_wb: wb=%h bus_err=%b expected 0 0", act, bus_err);
    end
    model_mo = 32'h0; last_alu = 32'h0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    clrn = 1'b1;
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd8, 1'b1, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (dmb.dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL nonmem_req_stall: req=%b stall=%b expected 0 0", dmb.dm_req, mem_stall);
    end
    sb.push_back('{1'b1, 1'b0, model_mo, 32'h1234, 5'd8});
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL nonmem_wb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++; $display("FAIL nonmem_wb: got %h expected %h", act, e);
      end
    end
    last_alu = 32'h1234;
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0106, 32'h0, 5'd2, 1'b1, 32'hCAFE_F00D);
    #1;
    checks++;
    if (dmb.dm_addr !== 32'h104 || dmb.dm_req !== 1'b1 || dmb.dm_we !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL zw_load_bus: addr=%h req=%b we=%b stall=%b expected 104 1 0 0",
                         dmb.dm_addr, dmb.dm_req, dmb.dm_we, mem_stall);
    end
    model_mo = 32'hCAFE_F00D;
    sb.push_back('{1'b1, 1'b1, model_mo, 32'h106, 5'd2});
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL zw_load_wb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++; $display("FAIL zw_load_wb: got %h expected %h", act, e);
      end
    end
    last_alu = 32'h106;
  endtask

  task automatic test_store_wait3();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'hA5A5_A5A5, 5'd6, (k == 4), 32'h1111_2222);
      if (k == 4) sb.push_back('{1'b0, 1'b0, model_mo, 32'h203, 5'd6});
      #1;
      checks++;
      if (dmb.dm_we !== 1'b1 || dmb.dm_req !== 1'b1 || dmb.dm_wdata !== 32'hA5A5_A5A5 ||
          dmb.dm_addr !== 32'h200 || mem_stall !== (k < 4)) begin
        errors++; $display("FAIL store_cycle%0d: we=%b req=%b wdata=%h addr=%h stall=%b expected 1 1 a5a5a5a5 200 %b",
                           k, dmb.dm_we, dmb.dm_req, dmb.dm_wdata, dmb.dm_addr, mem_stall, (k < 4));
      end
      @(posedge clk); #1;
      checks++;
      if (k < 4) begin
        if (wb_wreg !== 1'b0 || wb_m2reg !== 1'b0 || wb_alu !== last_alu) begin
          errors++; $display("FAIL store_bubble%0d: wreg=%b m2reg=%b alu=%h expected 0 0 %h",
                             k, wb_wreg, wb_m2reg, wb_alu, last_alu);
        end
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL store_wb: scoreboard empty");
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++; $display("FAIL store_wb: got %h expected %h", act, e);
        end
      end
    end
    last_alu = 32'h203;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++; $display("FAIL store_bus_err: got %b expected 0", bus_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [2];
    logic [4:0]  rn [2];
    rd[0] = 32'h1111_1111; rd[1] = 32'h2222_2222;
    rn[0] = 5'd3;          rn[1] = 5'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0, rn[i], 1'b1, rd[i]);
      #1;
      checks++;
      if (mem_stall !== 1'b0 || dmb.dm_req !== 1'b1) begin
        errors++; $display("FAIL b2b_stall%0d: stall=%b req=%b expected 0 1", i, mem_stall, dmb.dm_req);
      end
      model_mo = rd[i];
      sb.push_back('{1'b1, 1'b1, rd[i], 32'h10 + 32'(4 * i), rn[i]});
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL b2b_wb%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++; $display("FAIL b2b_wb%0d: got %h expected %h", i, act, e);
        end
      end
    end
    last_alu = 32'h14;
  endtask

  task automatic test_timeout();
    int  stalls = 0;
    bit  done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, 1'b0, 32'hDEAD_BEEF);
      #1;
      if (mem_stall === 1'b1) begin
        stalls++;
        @(posedge clk); #1;
        checks++;
        if (wb_wreg !== 1'b0) begin
          errors++; $display("FAIL timeout_bubble%0d: wreg=%b expected 0", k, wb_wreg);
        end
      end else begin
        done = 1;
        model_mo = ERR_D;
        sb.push_back('{1'b1, 1'b1, ERR_D, 32'h300, 5'd9});
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL timeout_wb: scoreboard empty");
        end else begin
          e = sb.pop_front();
          if (act !== e) begin
            errors++; $display("FAIL timeout_wb: got %h expected %h", act, e);
          end
        end
      end
    end
    checks++;
    if (!done || stalls != 4) begin
      errors++; $display("FAIL timeout_stall_len: done=%0d stalls=%0d expected 1 4", done, stalls);
    end
    checks++;
    if (bus_err !== 1'b1) begin
      errors++; $display("FAIL timeout_bus_err: got %b expected 1", bus_err);
    end
    last_alu = 32'h300;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd5, 1'b0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (dmb.dm_req !== 1'b1 || mem_stall !== 1'b1) begin
      errors++; $display("FAIL rst_wait_entry: req=%b stall=%b expected 1 1", dmb.dm_req, mem_stall);
    end
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++;
    if (dmb.dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rst_wait_req: req=%b stall=%b expected 0 0", dmb.dm_req, mem_stall);
    end
    checks++;
    if (act !== '0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rst_wait_wb: wb=%h bus_err=%b expected 0 0", act, bus_err);
    end
    sb.delete();
    model_mo = 32'h0; last_alu = 32'h0;
    @(negedge clk);
    clrn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmb.dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rst_wait_idle: req=%b stall=%b expected 0 0", dmb.dm_req, mem_stall);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_zero_wait_load();
    test_store_wait3();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_zero_wait_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer side of the EXE/MEM pipeline register.
- Takes the mem_* bundle and runs the data-memory access over a req/ack handshake, which may take several cycles.
- While an access is outstanding it stalls the upstream pipeline.
- Owns the MEM/WB pipeline register that feeds register-file writeback.

Parameters:
- MAX_WAIT, 15: maximum cycles spent in WAIT before the access is force-completed and a bus error is flagged (1..255).
- ERR_DATA, 32'h0000_0000: load data substituted when an access times out.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- mem_wreg  in  1  instruction in MEM writes the register file
- mem_m2reg  in  1  instruction in MEM is a load
- mem_wmem  in  1  instruction in MEM is a store
- mem_alu  in  32  ALU result; also the byte address for loads and stores
- mem_b  in  32  store data
- mem_rn  in  5  destination register number
- dm_req  out  1  data-memory request
- dm_we  out  1  data-memory write enable
- dm_addr  out  32  word-aligned address: {mem_alu[31:2],2'b00}
- dm_wdata  out  32  equals mem_b
- dm_rdata  in  32  read data, valid while dm_ack=1
- dm_ack  in  1  memory completes the request this cycle
- mem_stall  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM this cycle
- wb_wreg  out  1  registered: writeback enable
- wb_m2reg  out  1  registered: writeback selects memory data
- wb_mo  out  32  registered: load data
- wb_alu  out  32  registered: ALU result
- wb_rn  out  5  registered: destination register
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (clrn=0, asynchronous):
  - FSM goes to IDLE; wait counter cleared.
  - All wb_* outputs and bus_err go to 0.
  - dm_req=0 and mem_stall=0 while reset is asserted.
  - Reset during WAIT abandons the access. Memory must tolerate a dropped request.
- Definitions:
  - acc = mem_m2reg | mem_wmem
  - dm_we = mem_wmem & dm_req
  - dm_addr and dm_wdata are combinational from the inputs; they are don't-care when dm_req=0.
- FSM has two states, IDLE and WAIT.
  - IDLE, acc=0: dm_req=0, mem_stall=0. The instruction passes straight to MEM/WB.
  - IDLE, acc=1: dm_req=1 combinationally.
    - dm_ack=1 the same cycle: zero-wait completion, mem_stall=0, stay in IDLE.
    - Otherwise: mem_stall=1, go to WAIT, counter set to 1.
  - WAIT: dm_req=1 held; inputs are stable because upstream is stalled.
    - dm_ack=1: completion, mem_stall=0, go to IDLE.
    - Else if counter==MAX_WAIT: timeout completion. mem_stall=0, bus_err<=1, load data = ERR_DATA, go to IDLE.
    - Else: mem_stall=1, counter increments.
- dm_ack is ignored whenever dm_req=0.
- Upstream must not change the mem_* inputs while mem_stall=1.
- MEM/WB register, every rising clk:
  - mem_stall=0: wb_wreg<=mem_wreg, wb_m2reg<=mem_m2reg, wb_alu<=mem_alu, wb_rn<=mem_rn.
    - wb_mo<=dm_rdata on a normal load completion; ERR_DATA on a timed-out load; unchanged otherwise.
  - mem_stall=1: insert a bubble (wb_wreg<=0, wb_m2reg<=0); other wb_* values hold. Each instruction is therefore written back exactly once.
- Timing:
  - Writeback latency is 1 cycle after the completion cycle.
  - Stall length equals the number of memory wait cycles, at most MAX_WAIT.
- Store completion: a timed-out store also sets bus_err; wb_wreg then follows mem_wreg, which is normally 0 for stores.
- bus_err is cleared only by reset.
- Back-to-back accesses: a new access may begin in the cycle right after completion. No idle gap is required.

Decomposition:
- Shared pipeline package holds:
  - state encoding localparams S_IDLE=1'b0, S_WAIT=1'b1
  - REG_ADDR_W=5 and DATA_W=32
- One natural sub-module: mem_wb_register, the plain clear/bubble-capable MEM/WB flop bank. The handshake FSM and counter stay in the top module.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: start a load and drive clrn=0 while in WAIT.
  - Required: dm_req=0 and mem_stall=0 immediately; all wb_*=0; FSM back in IDLE after release.
- Non-memory op:
  - Stimulus: mem_wreg=1, mem_alu=32'h1234, mem_rn=5'd8, acc=0.
  - Required: dm_req=0 and mem_stall=0; next cycle wb_wreg=1, wb_alu=32'h1234, wb_rn=8.
- Zero-wait load:
  - Stimulus: mem_m2reg=1, mem_wreg=1, mem_alu=32'h0000_0106, dm_ack=1 in the same cycle, dm_rdata=32'hCAFE_F00D.
  - Required: dm_addr=32'h104, mem_stall=0; next cycle wb_mo=32'hCAFEF00D, wb_m2reg=1, wb_wreg=1.
- Three-wait store:
  - Stimulus: mem_wmem=1, mem_b=32'hA5A5_A5A5; dm_ack asserted on the 4th cycle of dm_req.
  - Required: dm_we=1 for 4 cycles; mem_stall=1 for cycles 1–3 and 0 on cycle 4; wb_wreg=0 throughout the stall; bus_err=0.
- Timeout:
  - Stimulus: MAX_WAIT=4, load with dm_ack never asserted.
  - Required: mem_stall=1 for exactly 4 cycles; bus_err=1; wb_mo=ERR_DATA, wb_wreg=1 one cycle after completion.
- Back-to-back zero-wait accesses:
  - Stimulus: load r3 then load r4 in consecutive cycles, both acked immediately.
  - Required: no stall; wb_rn=3 then wb_rn=4 on consecutive cycles, each with its own rdata.
